dii_packet_rx: RTL and testbench

DII_PACKET_RX -- requirements
Module: dii_packet_rx

---
 rtl/dii_package.sv | 26 ++
 rtl/dii_channel.sv | 21 ++
 rtl/dii_packet_rx.sv | 168 ++++++++++++++++
 tb/tb_dii_packet_rx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dii_package.sv
`default_nettype none
// ============================================================================
//  Module      : dii_package
//  Description : Shared constants and types for the DII packet receiver:
//                flit width, header flit indices, minimum legal packet
//                length and the receiver state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dii_package;

    localparam int FLIT_W      = 16;
    localparam int HDR_DEST    = 0;
    localparam int HDR_SRC     = 1;
    localparam int HDR_FLAGS   = 2;
    // A packet must at least carry the three header flits.
    localparam int MIN_PKT_LEN = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2,
        ST_FULL = 2'd3
    } rx_state_e;

endpackage : dii_package
`default_nettype wire

// File: rtl/dii_channel.sv
`default_nettype none
// ============================================================================
//  Module      : dii_channel
//  Description : DII flit channel. The master drives data/first/last/valid,
//                the slave answers with ready; a flit moves on a cycle where
//                valid and ready are both high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dii_channel;

    logic [dii_package::FLIT_W-1:0] data;
    logic                           first;
    logic                           last;
    logic                           valid;
    logic                           ready;

    modport master (output data, output first, output last, output valid, input  ready);
    modport slave  (input  data, input  first, input  last, input  valid, output ready);

endinterface : dii_channel
`default_nettype wire

// File: rtl/dii_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : dii_packet_rx
//  Description : Receives DII packets into a MAX_LEN x 16 register buffer and
//                holds a complete packet (>= 3 flits) until the consumer
//                acknowledges it. Malformed packets are discarded.
//  Ports       : clk, rst (async, active-high)
//                in          - DII slave channel (ready driven here)
//                pkt_valid   - a complete packet is held
//                pkt_ack     - consumer releases the held packet
//                pkt_len     - flit count of the held packet
//                pkt_dest/src/flags - header flits 0/1/2
//                rd_addr/rd_data    - combinational random read of the buffer
//                err_count   - saturating protocol error counter, present
//                              only when DII_PACKET_RX_ERR_CNT_EN is defined
//  Revision    : 1.0 - initial release
// ============================================================================
module dii_packet_rx
    import dii_package::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int LW      = $clog2(MAX_LEN + 1),
    localparam int AW      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    dii_channel.slave         in,
    output logic              pkt_valid,
    input  logic              pkt_ack,
    output logic [LW-1:0]     pkt_len,
    output logic [FLIT_W-1:0] pkt_dest,
    output logic [FLIT_W-1:0] pkt_src,
    output logic [FLIT_W-1:0] pkt_flags,
    input  logic [AW-1:0]     rd_addr,
    output logic [FLIT_W-1:0] rd_data
`ifdef DII_PACKET_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    rx_state_e         state_q, state_d;
    logic [LW-1:0]     len_q, len_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [FLIT_W-1:0] mem_q [MAX_LEN];

    logic              xfer;
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic              err;

    // Back-pressure is decoded straight from state so FULL stalls at once.
    assign in.ready = (state_q != ST_FULL);
    assign xfer     = in.valid & in.ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        err     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RECV: begin
                if (xfer) begin
                    if (in.first) begin
                        // A new header mid-packet abandons the partial packet.
                        err    = (state_q == ST_RECV);
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        len_d  = LW'(1);
                        if (in.last) begin
                            err     = 1'b1;
                            len_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RECV;
                        end
                    end else if (state_q == ST_IDLE) begin
                        err = 1'b1;
                    end else if (len_q == LW'(MAX_LEN)) begin
                        // Overlong: swallow the rest of the packet.
                        err     = 1'b1;
                        len_d   = '0;
                        state_d = in.last ? ST_IDLE : ST_DROP;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = len_q[AW-1:0];
                        len_d  = len_q + LW'(1);
                        if (in.last) begin
                            if (len_d >= LW'(MIN_PKT_LEN)) begin
                                state_d = ST_FULL;
                            end else begin
                                err     = 1'b1;
                                len_d   = '0;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            ST_DROP: begin
                if (xfer && in.last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (pkt_ack) begin
                    len_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pkt_valid_d = (state_d == ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            pkt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pkt_valid_q <= pkt_valid_d;
        end
    end

    // Data storage carries no reset; it is only meaningful below len_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= in.data;
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_len   = len_q;
    assign pkt_dest  = mem_q[HDR_DEST];
    assign pkt_src   = mem_q[HDR_SRC];
    assign pkt_flags = mem_q[HDR_FLAGS];
    assign rd_data   = mem_q[rd_addr];

`ifdef DII_PACKET_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_err;
    assign unused_err = err;
`endif

endmodule : dii_packet_rx
`default_nettype wire

// File: tb/tb_dii_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dii_packet_rx
//  Description : Self-checking bench for dii_packet_rx (MAX_LEN = 8): a
//                vector table, directed multi-cycle sequences and a random
//                phase compared against a queue-based packet model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dii_packet_rx;

    localparam int MAX_LEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_ack;
    logic [3:0]  pkt_len;
    logic        pkt_valid;
    logic [15:0] pkt_dest, pkt_src, pkt_flags, rd_data;
    logic [2:0]  rd_addr;
`ifdef DII_PACKET_RX_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    dii_channel ch ();

    dii_packet_rx #(.MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (ch.slave),
        .pkt_valid (pkt_valid),
        .pkt_ack   (pkt_ack),
        .pkt_len   (pkt_len),
        .pkt_dest  (pkt_dest),
        .pkt_src   (pkt_src),
        .pkt_flags (pkt_flags),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
`ifdef DII_PACKET_RX_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model: packets as queues ----------------
    logic [15:0] cur[$];
    logic [15:0] held[$];
    bit          holding;
    bit          dropping;
    int          err_m;

    task automatic model_reset();
        cur.delete();
        held.delete();
        holding  = 0;
        dropping = 0;
        err_m    = 0;
    endtask

    task automatic model_step(input bit v, input bit f, input bit l,
                              input logic [15:0] d, input bit ack);
        bit e    = 0;
        bit done = 0;
        if (holding) begin
            if (ack) begin
                holding = 0;
                held.delete();
            end
            return;
        end
        if (!v) return;
        if (dropping) begin
            if (l) dropping = 0;
            return;
        end
        if (f) begin
            e    = (cur.size() > 0);
            cur  = {d};
            done = l;
        end else if (cur.size() == 0) begin
            e = 1;
        end else if (cur.size() == MAX_LEN) begin
            e = 1;
            cur.delete();
            dropping = !l;
        end else begin
            cur.push_back(d);
            done = l;
        end
        if (done) begin
            if (cur.size() >= 3) begin
                held    = cur;
                holding = 1;
            end else begin
                e = 1;
            end
            cur.delete();
        end
        if (e && err_m < 255) err_m++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pkt_valid", 32'(pkt_valid), 32'(holding));
        chk("ready", 32'(ch.ready), 32'(!holding));
        if (holding) begin
            chk("pkt_len", 32'(pkt_len), 32'(held.size()));
            chk("pkt_dest", 32'(pkt_dest), 32'(held[0]));
            chk("pkt_src", 32'(pkt_src), 32'(held[1]));
            chk("pkt_flags", 32'(pkt_flags), 32'(held[2]));
            if (int'(rd_addr) < held.size())
                chk("rd_data", 32'(rd_data), 32'(held[rd_addr]));
        end
`ifdef DII_PACKET_RX_ERR_CNT_EN
        chk("err_count", 32'(err_count), 32'(err_m));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, update model, check.
    task automatic cycle(input bit v, input bit f, input bit l,
                         input logic [15:0] d, input bit ack);
        ch.valid = v;
        ch.first = f;
        ch.last  = l;
        ch.data  = d;
        pkt_ack  = ack;
        rd_addr  = 3'($urandom_range(0, 7));
        @(posedge clk);
        model_step(v, f, l, d, ack);
        #1;
        check_all();
    endtask

    task automatic send_pkt(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++)
            cycle(1'b1, i == 0, i == n - 1, base + 16'(i), 1'b0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          v, f, l;
        logic [15:0] d;
        bit          ack;
        bit          exp_valid;
        bit          exp_ready;
        int          exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ch.valid = 0; ch.first = 0; ch.last = 0; ch.data = '0;
        pkt_ack  = 0; rd_addr = '0;

        //         v  f  l  data      ack  valid ready err
        tbl[0] = '{1, 1, 0, 16'h0001, 0,   0,    1,    0};
        tbl[1] = '{1, 0, 0, 16'h0002, 0,   0,    1,    0};
        tbl[2] = '{1, 0, 1, 16'h0003, 0,   1,    0,    0};
        tbl[3] = '{1, 1, 0, 16'h00AA, 0,   1,    0,    0};
        tbl[4] = '{0, 0, 0, 16'h0000, 1,   0,    1,    0};
        tbl[5] = '{1, 1, 0, 16'h0011, 0,   0,    1,    0};
        tbl[6] = '{1, 0, 1, 16'h0012, 0,   0,    1,    1};
        tbl[7] = '{1, 1, 1, 16'h0021, 0,   0,    1,    2};
        tbl[8] = '{0, 0, 0, 16'h0000, 1,   0,    1,    2};
        tbl[9] = '{1, 0, 0, 16'h0030, 0,   0,    1,    3};

        // Reset state
        apply_reset();
        #1;
        chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        chk("rst_ready", 32'(ch.ready), 32'd1);
        chk("rst_pkt_len", 32'(pkt_len), 32'd0);
`ifdef DII_PACKET_RX_ERR_CNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif

        // Table: good 3-flit packet, stall while held, 2-flit, 1-flit, stray flit
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].d, tbl[i].ack);
            chk($sformatf("tbl%0d_valid", i), 32'(pkt_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_ready", i), 32'(ch.ready), 32'(tbl[i].exp_ready));
            if (i == 2) begin
                chk("tbl_dest", 32'(pkt_dest), 32'h0001);
                chk("tbl_src", 32'(pkt_src), 32'h0002);
                chk("tbl_flags", 32'(pkt_flags), 32'h0003);
                chk("tbl_len", 32'(pkt_len), 32'd3);
            end
`ifdef DII_PACKET_RX_ERR_CNT_EN
            chk($sformatf("tbl%0d_err", i), 32'(err_count), 32'(tbl[i].exp_err));
`endif
        end

        // Overlong 10-flit packet, then a good one
        apply_reset();
        send_pkt(10, 16'h0100);
        chk("long_no_valid", 32'(pkt_valid), 32'd0);
`ifdef DII_PACKET_RX_ERR_CNT_EN
        chk("long_err", 32'(err_count), 32'd1);
`endif
        send_pkt(3, 16'h0200);
        chk("after_long_dest", 32'(pkt_dest), 32'h0200);
        cycle(0, 0, 0, 16'h0, 1);

        // Restart after 4 flits
        for (int i = 0; i < 4; i++) cycle(1, i == 0, 0, 16'h0250 + 16'(i), 0);
        send_pkt(3, 16'h0300);
        chk("restart_dest", 32'(pkt_dest), 32'h0300);
        chk("restart_len", 32'(pkt_len), 32'd3);
`ifdef DII_PACKET_RX_ERR_CNT_EN
        chk("restart_err", 32'(err_count), 32'd2);
`endif
        cycle(0, 0, 0, 16'h0, 1);

        // Held packet with pending flits, ack, then back-to-back acceptance
        send_pkt(3, 16'h0400);
        cycle(1, 1, 0, 16'h0500, 0);
        cycle(1, 1, 0, 16'h0500, 0);
        cycle(1, 1, 0, 16'h0500, 1);
        chk("ack_ready", 32'(ch.ready), 32'd1);
        cycle(1, 1, 0, 16'h0500, 0);
        cycle(1, 0, 0, 16'h0501, 0);
        cycle(1, 0, 1, 16'h0502, 0);
        chk("b2b_valid", 32'(pkt_valid), 32'd1);
        chk("b2b_dest", 32'(pkt_dest), 32'h0500);
        chk("b2b_flags", 32'(pkt_flags), 32'h0502);
        cycle(0, 0, 0, 16'h0, 1);

        // Reset mid-packet
        cycle(1, 1, 0, 16'h0700, 0);
        cycle(1, 0, 0, 16'h0701, 0);
        rst = 1'b1;
        model_reset();
        #2;
        chk("midrst_valid", 32'(pkt_valid), 32'd0);
`ifdef DII_PACKET_RX_ERR_CNT_EN
        chk("midrst_err", 32'(err_count), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_pkt(3, 16'h0600);
        chk("post_rst_dest", 32'(pkt_dest), 32'h0600);
        chk("post_rst_src", 32'(pkt_src), 32'h0601);
        cycle(0, 0, 0, 16'h0, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0,
                  16'($urandom()),
                  $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dii_packet_rx
`default_nettype wire
